fetch_sequencer: RTL
====================

# fetch_sequencer

Sequences instruction fetch for the MIPS core: owns the architectural PC register, issues word reads to instruction memory over a req/ready handshake, and presents each fetched instruction with its PC to decode over a valid/accept handshake. Control-flow changes computed by the next-PC logic (branch taken, jump) arrive as a redirect. Redirects squash any in-flight or unconsumed fetch and restart fetch at the new PC.

## Interface
- RESET_PC, 30'h0000_0C00, word address loaded into PC on reset (byte address 0x0000_3000).
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; held high until imem_ready.
- imem_addr  out  [31:2]  word address of the request; stable while imem_req=1 and imem_ready=0.
- imem_ready  in  1  memory returns imem_rdata this cycle; meaningful only when imem_req=1.
- imem_rdata  in  32  instruction word, sampled when imem_req & imem_ready.
- instr_valid  out  1  instr/instr_pc hold a live instruction.
- instr  out  32  fetched instruction.
- instr_pc  out  [31:2]  word address of instr.
- instr_accept  in  1  decode consumes instr this cycle; ignored when instr_valid=0.
- redirect  in  1  one-cycle pulse: change PC to redirect_pc.
- redirect_pc  in  [31:2]  target word address (branch: pc+1+sext(offset); jump: target).
- fetch_count  out  32  instructions delivered (accepted), wraps.
- kill_count  out  32  fetches discarded due to redirect, wraps.

## Operation
- Registers: pc [31:2], state, kill flag, instr/instr_pc holding registers, two counters.
- States: IDLE, REQ, OUT.
- IDLE: entered by reset for exactly one cycle; imem_req=0; next state REQ.
- REQ: imem_req=1, imem_addr=pc. On imem_ready: if kill=0 capture imem_rdata into instr, pc into instr_pc, go OUT; if kill=1 discard data, clear kill, kill_count+1, stay REQ (new request at updated pc next cycle).
- OUT: instr_valid=1, imem_req=0. On instr_accept: fetch_count+1, pc<=pc+1, go REQ.
- PC arithmetic: 30-bit word address, pc+1 wraps 30'h3FFF_FFFF -> 0; no byte-offset bits exist.
- Redirect (priority over all other events):
  - IDLE: pc<=redirect_pc; go REQ.
  - REQ with imem_ready=0: pc not changed visibly on imem_addr; target stored, kill<=1; address applied once the outstanding request completes (imem_addr stability rule).
  - REQ with imem_ready=1: returned data discarded, kill_count+1, pc<=redirect_pc, stay REQ.
  - OUT without accept: instr_valid drops next cycle, kill_count+1, pc<=redirect_pc, go REQ.
  - OUT with accept same cycle: instruction counted as delivered (fetch_count+1, it is the redirecting instruction), pc<=redirect_pc (not pc+1), go REQ.
  - Second redirect while kill=1: overwrites stored target; kill stays 1; last target wins.
- Counters saturate never; wrap at 2^32.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=RESET_PC, fetch_count=0, kill_count=0, state=IDLE, kill=0.
- Reset anywhere (incl. mid-request) abandons the request: imem_req=0 next cycle; memory must tolerate a dropped request.
- First imem_req=1 at cycle 2 after rst deasserts (IDLE occupies cycle 1).
- Zero-wait memory: REQ(ready) -> OUT next cycle -> accept -> REQ next cycle: one instruction per 2 cycles peak.
- Each memory wait cycle adds one cycle; each decode stall cycle adds one cycle.
- Redirect latency: request to redirect_pc asserted the cycle after redirect (REQ/OUT/IDLE cases), or the cycle after the outstanding request completes (kill case).
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- Reset/sequential: rst 3 cycles, ready=1, accept=1 always -> imem_addr 0xC00, 0xC01, 0xC02 on successive REQ cycles; instr_pc matches; fetch_count=3 after 3 accepts.
- Backpressure/wait: ready delayed 3 cycles, accept delayed 2 -> imem_addr stable during wait, instr stable while valid, no duplicate or skipped PC.
- Redirect in OUT: valid at pc 0xC05, redirect_pc=0xD00 without accept -> valid drops, next request 0xD00, kill_count=1, fetch_count unchanged.
- Redirect during wait: REQ at 0xC02, ready=0, redirect to 0xE00, ready next cycle -> data dropped, then request 0xE00, kill_count+1, first delivered instr_pc=0xE00.
- Accept+redirect same cycle: accept instr at 0xC03 with redirect 0xC10 -> fetch_count+1, kill_count unchanged, next request 0xC10.
- Wrap and reset mid-op: pc 30'h3FFF_FFFF accepted -> next request 0x0; rst asserted in REQ -> imem_req=0 next cycle, outputs at reset values.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, fetches words from imem, hands them to decode.
// Ports: clk/rst, imem req/addr/ready/rdata, instr valid/pc/accept, redirect, counters.
module fetch_sequencer #(
  parameter logic [29:0] RESET_PC = 30'h0000_0C00
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:2] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:2] instr_pc,
  input  logic        instr_accept,
  input  logic        redirect,
  input  logic [31:2] redirect_pc,
  output logic [31:0] fetch_count,
  output logic [31:0] kill_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [31:2] pc;
  logic [31:2] tgt;
  logic        kill;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: state_n = S_REQ;
      S_REQ: begin
        if (redirect)                state_n = S_REQ;
        else if (imem_ready && !kill) state_n = S_OUT;
      end
      S_OUT: begin
        if (redirect || instr_accept) state_n = S_REQ;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs decode registered state only; no input reaches an output.
  always_comb begin
    imem_req    = (state == S_REQ);
    instr_valid = (state == S_OUT);
    imem_addr   = pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      tgt         <= RESET_PC;
      kill        <= 1'b0;
      instr       <= 32'd0;
      instr_pc    <= RESET_PC;
      fetch_count <= 32'd0;
      kill_count  <= 32'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (redirect) pc <= redirect_pc;
        end
        S_REQ: begin
          if (imem_ready) begin
            if (redirect) begin
              pc         <= redirect_pc;
              kill       <= 1'b0;
              kill_count <= kill_count + 32'd1;
            end else if (kill) begin
              // Stale response: drop it, then refetch at the held target.
              pc         <= tgt;
              kill       <= 1'b0;
              kill_count <= kill_count + 32'd1;
            end else begin
              instr    <= imem_rdata;
              instr_pc <= pc;
            end
          end else if (redirect) begin
            // imem_addr must stay put until the request completes.
            tgt  <= redirect_pc;
            kill <= 1'b1;
          end
        end
        S_OUT: begin
          if (redirect) begin
            pc <= redirect_pc;
            if (instr_accept) fetch_count <= fetch_count + 32'd1;
            else              kill_count  <= kill_count + 32'd1;
          end else if (instr_accept) begin
            fetch_count <= fetch_count + 32'd1;
            pc          <= pc + 30'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
